branch_target_unit: RTL
=======================

Name: branch_target_unit

Overview:
- Parametrised successor to the ID-stage branch destination adder: resolves branch/jump targets and adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- IF stage queries it with the fetch PC for a predicted next PC.
- ID/EX stage feeds resolved branches back; the block computes the true target, trains the BTB and raises a registered redirect on mispredict.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 16, BTB entry count; power of 2, ≥2; IDX_W = log2(ENTRIES); tag = pc[XLEN-1:IDX_W+2].
- RAS_DEPTH, 4, return-address-stack depth (used only with BTU_RAS_EN).

Ports:
- clk  in  1  core clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  invalidate all BTB entries and cancel the current update
- if_pc  in  XLEN  fetch PC to look up
- pred_taken  out  1  BTB hit and counter[1]==1
- pred_target  out  XLEN  predicted target; 0 when pred_taken==0
- upd_valid  in  1  resolved branch/jump present this cycle
- upd_op  in  2  00 none, 01 PC_RELATIVE, 10 REG_OFFSET, 11 reserved
- upd_cond  in  1  1 = conditional branch, 0 = JAL/JALR
- upd_taken  in  1  actual outcome (1 for jumps)
- upd_pc  in  XLEN  PC of resolving instruction
- upd_base  in  XLEN  rs1 data for REG_OFFSET
- upd_imm  in  XLEN  sign-extended immediate
- upd_pred_taken  in  1  prediction carried down the pipe for this instruction
- upd_pred_target  in  XLEN  predicted target carried down the pipe
- upd_is_call  in  1  instruction is a call (rd=x1/x5)
- upd_is_ret  in  1  instruction is a return (JALR rs1=x1/x5, rd=x0)
- res_target  out  XLEN  combinational resolved target
- redirect_valid  out  1  registered mispredict strobe
- redirect_pc  out  XLEN  registered correct next PC

Behaviour:
- Reset (async, resetn low): all valid bits 0, counters 2'b00, redirect_valid 0, redirect_pc 0. pred_taken/pred_target therefore read 0; res_target is combinational only.
- res_target:
  - PC_RELATIVE: upd_pc + upd_imm.
  - REG_OFFSET: (upd_base + upd_imm) with bit 0 cleared.
  - 00/11: 0.
  - Sums wrap modulo 2^XLEN.
- Lookup (combinational from registered state, zero latency): idx = if_pc[IDX_W+1:2]; hit = valid[idx] && tag match; pred_taken = hit && ctr[idx][1].
- Training on the clock edge when upd_valid, op ∈ {01,10} and not flush:
  - Hit, conditional: counter ±1 saturating at 00/11 per upd_taken.
  - Hit, jump: counter set to 11.
  - Hit and taken: stored target overwritten with res_target.
  - Miss and taken: allocate; tag, target=res_target, counter = 10 if conditional else 11; evicts the previous occupant.
  - Miss and not taken: no write.
- Mispredict condition:
  - (upd_taken != upd_pred_taken), or
  - (upd_taken && upd_pred_target != res_target).
- Redirect timing: on mispredict, at the next edge redirect_valid=1 and redirect_pc = upd_taken ? res_target : upd_pc+4. Otherwise redirect_valid=0. Redirect is a 1-cycle pulse; there is no backpressure.
- Same-index lookup and update in one cycle: lookup returns pre-update state; the new state is visible the following cycle.
- flush: all valid bits cleared at the edge. flush has priority over any same-cycle update (no training, redirect_valid forced 0). Counters and targets are not cleared.
- Reserved op or upd_valid=0: no state change, redirect_valid=0 next cycle.
- Reset mid-operation: immediate clear regardless of pending update.

Optional Feature:
- Macro: BTU_RAS_EN.
- Defined:
  - BTB entries carry a ret bit, written from upd_is_ret on allocate/update.
  - On a hit whose ret bit is set, pred_target = RAS top.
  - At resolution: push upd_pc+4 on upd_is_call; pop on upd_is_ret; call+ret together pops then pushes.
  - Overflow wraps, overwriting the oldest entry. Pop when empty leaves count 0; top reads 0.
  - flush does not alter the RAS; resetn empties it.
- Undefined: upd_is_call/upd_is_ret ignored, no RAS storage, ret entries use the stored target.

Test Plan:
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0; res_target=0 with upd_op=00.
- Taken cond branch upd_pc=0x100, imm=0x40, pred 0 → next cycle redirect_valid=1, redirect_pc=0x140; then if_pc=0x100 → pred_taken=1, pred_target=0x140.
- Same branch resolved not-taken twice from counter 10 → counter 00; if_pc=0x100 → pred_taken=0; second resolve with upd_pred_taken=0 → no redirect.
- JALR base=0x2001, imm=0x6 → res_target=0x2006; upd_pc=0xFFFFFFFC, imm=0x8 PC_RELATIVE → res_target=0x4 (wrap).
- flush asserted with a taken update to a new index → no allocation, redirect_valid=0; previously valid entries miss the next cycle.
- (BTU_RAS_EN) call at 0x300 pushes 0x304; ret entry hit → pred_target=0x304; five calls with RAS_DEPTH=4 then four rets → 2nd..5th return addresses popped in LIFO order, fifth pop on empty → 0.

Source files
------------

// File: rtl/branch_target_unit_if.sv
// Lookup, resolve/train and redirect signals between the fetch/execute stages
// and branch_target_unit. The core side drives through the master modport.
interface branch_target_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            upd_valid;
  logic [1:0]      upd_op;
  logic            upd_cond;
  logic            upd_taken;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_base;
  logic [XLEN-1:0] upd_imm;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            upd_is_call;
  logic            upd_is_ret;

  logic [XLEN-1:0] res_target;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output if_pc, upd_valid, upd_op, upd_cond, upd_taken, upd_pc, upd_base,
           upd_imm, upd_pred_taken, upd_pred_target, upd_is_call, upd_is_ret,
    input  pred_taken, pred_target, res_target, redirect_valid, redirect_pc
  );

  modport slave (
    input  if_pc, upd_valid, upd_op, upd_cond, upd_taken, upd_pc, upd_base,
           upd_imm, upd_pred_taken, upd_pred_target, upd_is_call, upd_is_ret,
    output pred_taken, pred_target, res_target, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_target_unit.sv
// Branch target resolution plus direct-mapped BTB with 2-bit direction counters.
// Define BTU_RAS_EN to add a return-address stack feeding ret-marked BTB hits.
module branch_target_unit #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int RAS_DEPTH = 4
) (
  input logic                 clk,
  input logic                 resetn,
  input logic                 flush,
  branch_target_unit_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [1:0] OP_PCREL  = 2'b01;
  localparam logic [1:0] OP_REGOFF = 2'b10;

  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [XLEN-1:0] calc_target(input logic [1:0]      op,
                                                  input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] base,
                                                  input logic [XLEN-1:0] imm);
    logic [XLEN-1:0] sum;
    sum = base + imm;
    case (op)
      OP_PCREL:  return pc + imm;
      OP_REGOFF: return {sum[XLEN-1:1], 1'b0};
      default:   return '0;
    endcase
  endfunction

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];

  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;

  logic [IDX_W-1:0] lk_idx, u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             lk_hit, lk_taken, u_hit, upd_en, tw_en, ctr_we, mispredict;
  logic [1:0]       ctr_d;
  logic [XLEN-1:0]  res, lk_tgt;

  logic unused_bits;
  assign unused_bits = ^bus.if_pc[1:0];

  assign res    = calc_target(bus.upd_op, bus.upd_pc, bus.upd_base, bus.upd_imm);
  assign upd_en = bus.upd_valid && !flush &&
                  (bus.upd_op == OP_PCREL || bus.upd_op == OP_REGOFF);
  assign u_idx  = bus.upd_pc[IDX_W+1:2];
  assign u_tag  = bus.upd_pc[XLEN-1:IDX_W+2];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign tw_en  = upd_en && bus.upd_taken;
  assign ctr_we = upd_en && (u_hit || bus.upd_taken);

`ifdef BTU_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - PTR_W'(1);
  endfunction

  logic [ENTRIES-1:0] ret_q;
  logic [XLEN-1:0]    ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]   ras_ptr_q, ras_ptr_d, ras_widx;
  logic [CNT_W-1:0]   ras_cnt_q, ras_cnt_d;
  logic               ras_we;
  logic [XLEN-1:0]    ras_top;

  assign ras_top = (ras_cnt_q == '0) ? '0 : ras_q[ptr_dec(ras_ptr_q)];

  // Pop is applied before push so call+ret replaces the top in place.
  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_widx  = ras_ptr_q;
    if (upd_en && bus.upd_is_ret && ras_cnt_q != '0) begin
      ras_ptr_d = ptr_dec(ras_ptr_q);
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end
    if (upd_en && bus.upd_is_call) begin
      ras_we    = 1'b1;
      ras_widx  = ras_ptr_d;
      ras_ptr_d = ptr_inc(ras_ptr_d);
      if (ras_cnt_d != CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_widx] <= bus.upd_pc + XLEN'(4);
    if (ctr_we) ret_q[u_idx]    <= bus.upd_is_ret;
  end

  assign lk_tgt = ret_q[lk_idx] ? ras_top : tgt_q[lk_idx];
`else
  logic unused_ras;
  assign unused_ras = bus.upd_is_call ^ bus.upd_is_ret;
  assign lk_tgt     = tgt_q[lk_idx];
`endif

  // Lookup sees pre-update state; training lands at the next edge.
  assign lk_idx          = bus.if_pc[IDX_W+1:2];
  assign lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == bus.if_pc[XLEN-1:IDX_W+2]);
  assign lk_taken        = lk_hit && ctr_q[lk_idx][1];
  assign bus.pred_taken  = lk_taken;
  assign bus.pred_target = lk_taken ? lk_tgt : '0;
  assign bus.res_target  = res;

  always_comb begin
    valid_d = valid_q;
    if (flush)      valid_d = '0;
    else if (tw_en) valid_d[u_idx] = 1'b1;
  end

  always_comb begin
    ctr_d = bus.upd_cond ? 2'b10 : 2'b11;
    if (u_hit) ctr_d = bus.upd_cond ? sat_ctr(ctr_q[u_idx], bus.upd_taken) : 2'b11;
  end

  always_comb begin
    mispredict       = upd_en && ((bus.upd_taken != bus.upd_pred_taken) ||
                                  (bus.upd_taken && bus.upd_pred_target != res));
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    if (mispredict) redirect_pc_d = bus.upd_taken ? res : bus.upd_pc + XLEN'(4);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else begin
      valid_q          <= valid_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      if (ctr_we) ctr_q[u_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tw_en) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= res;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
endmodule
